// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one memory op from execute, drives a req/gnt/rvalid
// data-memory handshake, aligns/extends load data and flags bad accesses.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic [4:0]            ex_rd,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  exc_valid,
    output logic [3:0]            exc_cause,
    output logic [ADDR_WIDTH-1:0] exc_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_EXC
    } state_e;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_LD_ALIGN = 4'd4;
    localparam logic [3:0] CAUSE_ST_ALIGN = 4'd6;

    state_e                  state_q;
    logic                    is_store_q;
    logic [2:0]              funct3_q;
    logic [1:0]              addr_lo_q;
    logic [4:0]              rd_q;
    logic                    wb_valid_q;
    logic [4:0]              wb_rd_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic                    exc_valid_q;
    logic [3:0]              exc_cause_q;
    logic [ADDR_WIDTH-1:0]   exc_addr_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [3:0]              mem_be_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic                    illegal_d;
    logic                    misalign_d;
    logic [3:0]              be_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   shifted_d;
    logic [DATA_WIDTH-1:0]   load_d;

    // Decode of the op presented by execute; only consumed on the accept edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        illegal_d  = 1'b0;
        misalign_d = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = '0;
        if (ex_is_store) begin
            illegal_d = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
        end else begin
            illegal_d = !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misalign_d = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                     ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
        case (ex_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ex_addr[1:0];
                wdata_d = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << ex_addr[1:0];
                wdata_d = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = ex_wdata;
            end
        endcase
        if (!ex_is_store) begin
            wdata_d = '0;
        end
    end

    // Load alignment uses the size and offset captured at accept.
    always_comb begin
        shifted_d = mem_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b100:  load_d = {24'd0, shifted_d[7:0]};
            3'b001:  load_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b101:  load_d = {16'd0, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: state and registered outputs use <= so every branch sees pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        is_store_q <= ex_is_store;
                        funct3_q   <= ex_funct3;
                        addr_lo_q  <= ex_addr[1:0];
                        rd_q       <= ex_rd;
                        if (illegal_d || misalign_d) begin
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= illegal_d   ? CAUSE_ILLEGAL :
                                           ex_is_store ? CAUSE_ST_ALIGN : CAUSE_LD_ALIGN;
                            exc_addr_q  <= ex_addr;
                            state_q     <= S_EXC;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ex_is_store;
                            mem_be_q    <= be_d;
                            mem_addr_q  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (is_store_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= load_d;
                            state_q    <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    wb_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                S_EXC: begin
                    exc_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Held low while reset is asserted so every output reads 0 in reset.
    assign ex_ready  = rst_n && (state_q == S_IDLE);
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: inputs driven and outputs checked on the
// falling clock edge, expected values hand-computed.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_is_store(ex_is_store),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one op for a single edge; returns at the negedge after acceptance.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = addr;
        ex_wdata    = wdata;
        ex_rd       = rd;
        tick();
        ex_valid    = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b0, f3, addr, 32'hDEAD_BEEF, rd);
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_be"}, mem_be, exp_be);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, ex_ready, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, "_req_fall"}, mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_wbdata"}, wb_data, exp_data);
        check({tag, "_wbrd"}, wb_rd, rd);
        check({tag, "_noexc"}, exc_valid, 0);
        tick();
        check({tag, "_wbv_off"}, wb_valid, 0);
        check({tag, "_ready"}, ex_ready, 1);
        check({tag, "_hold"}, wb_data, exp_data);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        issue(1'b1, f3, addr, wdata, 5'd0);
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_we"}, mem_we, 1);
        check({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_be"}, mem_be, exp_be);
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check({tag, "_nowb"}, wb_valid, 0);
        check({tag, "_ready"}, ex_ready, 1);
    endtask

    task automatic do_exc(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [3:0] exp_cause);
        issue(st, f3, addr, 32'h1234_5678, 5'd7);
        check({tag, "_excv"}, exc_valid, 1);
        check({tag, "_cause"}, exc_cause, exp_cause);
        check({tag, "_eaddr"}, exc_addr, addr);
        check({tag, "_noreq"}, mem_req, 0);
        check({tag, "_nowb"}, wb_valid, 0);
        check({tag, "_busy"}, ex_ready, 0);
        tick();
        check({tag, "_excv_off"}, exc_valid, 0);
        check({tag, "_noreq2"}, mem_req, 0);
        check({tag, "_ready"}, ex_ready, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3   = 3'b000;
        ex_addr     = 32'h0;
        ex_wdata    = 32'h0;
        ex_rd       = 5'd0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;

        // Reset state
        tick();
        check("rst_ready", ex_ready, 0);
        check("rst_req", mem_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_excv", exc_valid, 0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_ready", ex_ready, 1);
        tick();

        // Loads: sign/zero extension across lanes
        do_load("lb_1003", 3'b000, 32'h0000_1003, 32'h8011_2233, 5'd5, 4'b1000, 32'hFFFF_FF80);
        do_load("lhu_2002", 3'b101, 32'h0000_2002, 32'hBEEF_1234, 5'd6, 4'b1100, 32'h0000_BEEF);
        do_load("lh_2002", 3'b001, 32'h0000_2002, 32'hBEEF_1234, 5'd7, 4'b1100, 32'hFFFF_BEEF);
        do_load("lbu_1001", 3'b100, 32'h0000_1001, 32'h8011_22F3, 5'd8, 4'b0010, 32'h0000_0022);
        do_load("lh_0", 3'b001, 32'h0000_0100, 32'h0000_8001, 5'd9, 4'b0011, 32'hFFFF_8001);
        do_load("lw_4000", 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd31, 4'b1111, 32'hCAFE_F00D);

        // Stores: lane replication and byte enables
        do_store("sb_0001", 3'b000, 32'h0000_0001, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        do_store("sh_0002", 3'b001, 32'h0000_0002, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF);
        do_store("sw_0008", 3'b010, 32'h0000_0008, 32'h8765_4321, 4'b1111, 32'h8765_4321);

        // Exceptions never touch memory
        do_exc("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 4'd4);
        do_exc("sh_mis", 1'b1, 3'b001, 32'h0000_0003, 4'd6);
        do_exc("st_f3_100", 1'b1, 3'b100, 32'h0000_0010, 4'd2);
        do_exc("ld_f3_011", 1'b0, 3'b011, 32'h0000_0020, 4'd2);

        // Delayed grant, busy-time ex_valid ignored until back in IDLE
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd12);
        ex_valid    = 1'b1;
        ex_is_store = 1'b1;
        ex_funct3   = 3'b010;
        ex_addr     = 32'h0000_0050;
        ex_wdata    = 32'h5555_AAAA;
        ex_rd       = 5'd0;
        for (int i = 0; i < 3; i++) begin
            check("dly_req", mem_req, 1);
            check("dly_addr", mem_addr, 32'h0000_3000);
            check("dly_be", mem_be, 4'b1111);
            check("dly_we", mem_we, 0);
            check("dly_busy", ex_ready, 0);
            tick();
        end
        check("dly_req4", mem_req, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("dly_wait_req", mem_req, 0);
        check("dly_wait_busy", ex_ready, 0);
        tick();
        check("dly_wait2_busy", ex_ready, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0;
        check("dly_wbv", wb_valid, 1);
        check("dly_wbdata", wb_data, 32'h0BAD_F00D);
        check("dly_wbrd", wb_rd, 12);
        check("dly_resp_busy", ex_ready, 0);
        tick();
        check("dly_idle_ready", ex_ready, 1);
        check("dly_idle_noreq", mem_req, 0);
        tick();
        ex_valid = 1'b0;
        check("dly2_req", mem_req, 1);
        check("dly2_we", mem_we, 1);
        check("dly2_addr", mem_addr, 32'h0000_0050);
        check("dly2_wdata", mem_wdata, 32'h5555_AAAA);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("dly2_ready", ex_ready, 1);

        // Reset asserted while waiting for the response
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_req", mem_req, 0);
        check("rstw_addr", mem_addr, 0);
        check("rstw_be", mem_be, 0);
        check("rstw_ready", ex_ready, 0);
        check("rstw_wbv", wb_valid, 0);
        check("rstw_wbdata", wb_data, 0);
        check("rstw_excv", exc_valid, 0);
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        check("rstw_stale_wbv", wb_valid, 0);
        check("rstw_post_ready", ex_ready, 1);
        do_load("lb_post", 3'b000, 32'h0000_0042, 32'h7F00_0000, 5'd4, 4'b0100, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
